// File: rtl/quiz_round_controller.sv
// quiz_round_controller
// Fastest-finger-first round sequencer: synchronizes and edge-detects the
// contestant buzzers, picks the lowest-index new press while armed, runs a
// bounded answer window for the winner, applies host verdicts, tracks
// per-round lockouts (wrong answers, timeouts, false starts) and keeps a
// saturating score per contestant.

module quiz_round_controller #(
    parameter int N_USERS       = 4,
    parameter int ANSWER_CYCLES = 1000,
    parameter int SCORE_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_round,
    input  logic [N_USERS-1:0]           buzzer,
    input  logic                         verdict_valid,
    input  logic                         verdict_correct,
    output logic                         armed,
    output logic [N_USERS-1:0]           winner,
    output logic                         winner_valid,
    output logic [N_USERS-1:0]           lockout,
    output logic                         timeout,
    output logic                         round_done,
    output logic [N_USERS*SCORE_W-1:0]   scores
);

    localparam int CNT_W = $clog2(ANSWER_CYCLES);
    localparam int IDX_W = $clog2(N_USERS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_ANSWER,
        S_CLOSE
    } state_t;

    state_t                           state;
    logic [N_USERS-1:0]               sync1;
    logic [N_USERS-1:0]               sync2;
    logic [N_USERS-1:0]               sync2_d;
    logic [N_USERS-1:0]               rise;
    logic [N_USERS-1:0]               cand;
    logic [N_USERS-1:0]               pick_oh;
    logic [IDX_W-1:0]                 pick_idx;
    logic [IDX_W-1:0]                 win_idx;
    logic [N_USERS-1:0]               false_start;
    logic [N_USERS-1:0]               lock_after_miss;
    logic [CNT_W-1:0]                 cnt;
    logic [N_USERS-1:0][SCORE_W-1:0]  score_r;

    assign rise            = sync2 & ~sync2_d;
    assign cand            = rise & ~lockout;
    assign lock_after_miss = lockout | winner;
    assign scores          = score_r;

    // Two-flop synchronizer plus one delay stage for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            sync2_d <= '0;
        end else begin
            sync1   <= buzzer;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    // Lowest-index priority pick among eligible new presses.
    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        for (int i = N_USERS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick_oh    = '0;
                pick_oh[i] = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end

    // Round FSM with registered outputs, answer timer and score update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            armed        <= 1'b0;
            winner       <= '0;
            winner_valid <= 1'b0;
            win_idx      <= '0;
            lockout      <= '0;
            false_start  <= '0;
            timeout      <= 1'b0;
            round_done   <= 1'b0;
            cnt          <= '0;
            score_r      <= '0;
        end else begin
            timeout    <= 1'b0;
            round_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_round) begin
                        // Presses seen while idle (this cycle included) stay barred.
                        lockout     <= false_start | rise;
                        false_start <= '0;
                        armed       <= 1'b1;
                        state       <= S_ARMED;
                    end else begin
                        lockout     <= lockout | rise;
                        false_start <= false_start | rise;
                    end
                end
                S_ARMED: begin
                    if (|cand) begin
                        winner       <= pick_oh;
                        win_idx      <= pick_idx;
                        winner_valid <= 1'b1;
                        armed        <= 1'b0;
                        cnt          <= CNT_W'(ANSWER_CYCLES - 1);
                        state        <= S_ANSWER;
                    end
                end
                S_ANSWER: begin
                    cnt <= cnt - CNT_W'(1);
                    if (verdict_valid && verdict_correct) begin
                        if (!(&score_r[win_idx])) begin
                            score_r[win_idx] <= score_r[win_idx] + SCORE_W'(1);
                        end
                        state <= S_CLOSE;
                    end else if (verdict_valid || (cnt == '0)) begin
                        // A verdict on the expiry cycle wins over the timeout.
                        timeout <= ~verdict_valid;
                        lockout <= lock_after_miss;
                        if (&lock_after_miss) begin
                            state <= S_CLOSE;
                        end else begin
                            winner       <= '0;
                            winner_valid <= 1'b0;
                            armed        <= 1'b1;
                            state        <= S_ARMED;
                        end
                    end
                end
                S_CLOSE: begin
                    round_done   <= 1'b1;
                    winner       <= '0;
                    winner_valid <= 1'b0;
                    state        <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quiz_round_controller.sv
// Testbench for quiz_round_controller: directed vector table, hand-written
// corner sequences and randomized traffic, all checked against an
// event-level reference model of the round rules.

module tb_quiz_round_controller;

    localparam int N    = 4;
    localparam int AC   = 8;
    localparam int SW   = 8;
    localparam int SMAX = (1 << SW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_round;
    logic [N-1:0]    buzzer;
    logic            verdict_valid;
    logic            verdict_correct;
    logic            armed;
    logic [N-1:0]    winner;
    logic            winner_valid;
    logic [N-1:0]    lockout;
    logic            timeout;
    logic            round_done;
    logic [N*SW-1:0] scores;

    quiz_round_controller #(
        .N_USERS       (N),
        .ANSWER_CYCLES (AC),
        .SCORE_W       (SW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_round     (start_round),
        .buzzer          (buzzer),
        .verdict_valid   (verdict_valid),
        .verdict_correct (verdict_correct),
        .armed           (armed),
        .winner          (winner),
        .winner_valid    (winner_valid),
        .lockout         (lockout),
        .timeout         (timeout),
        .round_done      (round_done),
        .scores          (scores)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: round phase, absolute answer deadline, per-user scores.
    int           m_phase;     // 0 idle, 1 accepting presses, 2 answering, 3 closing
    int           m_win;       // answering contestant index, -1 if none
    int           m_cyc;
    int           m_deadline;
    logic [N-1:0] m_lock;
    logic [N-1:0] m_fs;
    logic [N-1:0] m_hist [3];  // buzzer as sampled 1, 2 and 3 edges ago
    int           m_score [N];
    logic         m_timeout;
    logic         m_done;

    typedef struct {
        logic         st;
        logic [N-1:0] bz;
        logic         vv;
        logic         vc;
        logic         e_armed;
        logic [N-1:0] e_win;
        logic [N-1:0] e_lock;
        logic         e_done;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase    = 0;
        m_win      = -1;
        m_cyc      = 0;
        m_deadline = 0;
        m_lock     = '0;
        m_fs       = '0;
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
        for (int i = 0; i < N; i++) m_score[i] = 0;
        m_timeout  = 1'b0;
        m_done     = 1'b0;
    endtask

    task automatic model_step();
        logic [N-1:0] presses;
        logic [N-1:0] eligible;
        presses   = m_hist[1] & ~m_hist[2];
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = buzzer;
        m_cyc++;
        m_timeout = 1'b0;
        m_done    = 1'b0;
        if (m_phase == 0) begin
            m_lock = m_lock | presses;
            m_fs   = m_fs | presses;
            if (start_round) begin
                m_lock  = m_fs;
                m_fs    = '0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            eligible = presses & ~m_lock;
            if (eligible != '0) begin
                for (int i = N - 1; i >= 0; i--) if (eligible[i]) m_win = i;
                m_deadline = m_cyc + AC;
                m_phase    = 2;
            end
        end else if (m_phase == 2) begin
            if (verdict_valid && verdict_correct) begin
                m_score[m_win] = (m_score[m_win] >= SMAX) ? SMAX : m_score[m_win] + 1;
                m_phase = 3;
            end else if (verdict_valid || m_cyc == m_deadline) begin
                m_timeout     = !verdict_valid;
                m_lock[m_win] = 1'b1;
                if (m_lock == '1) begin
                    m_phase = 3;
                end else begin
                    m_win   = -1;
                    m_phase = 1;
                end
            end
        end else begin
            m_done  = 1'b1;
            m_win   = -1;
            m_phase = 0;
        end
    endtask

    task automatic check_model();
        logic [N-1:0]    ew;
        logic [N*SW-1:0] es;
        ew = '0;
        if (m_win >= 0) ew[m_win] = 1'b1;
        for (int i = 0; i < N; i++) es[i*SW +: SW] = SW'(m_score[i]);
        check("model_ctl", {armed, winner_valid, timeout, round_done, winner, lockout},
              {(m_phase == 1), (m_win >= 0), m_timeout, m_done, ew, m_lock});
        check("model_scores", scores, es);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic round_user0();
        start_round = 1'b1;
        tick();
        start_round = 1'b0;
        buzzer = 4'b0001;
        ticks(3);
        buzzer = 4'b0000;
        verdict_valid = 1'b1;
        verdict_correct = 1'b1;
        tick();
        verdict_valid = 1'b0;
        ticks(2);
    endtask

    initial begin
        rst = 1'b1;
        start_round = 1'b0;
        buzzer = '0;
        verdict_valid = 1'b0;
        verdict_correct = 1'b0;
        model_reset();

        //               st bz       vv  vc   armed win      lock     done
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b1010, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b1010, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 4'b1001, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 4'b1001, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1001, 1'b0});
        tbl.push_back('{1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1001, 1'b0});
        tbl.push_back('{1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1001, 1'b0});
        tbl.push_back('{1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b1001, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1011, 1'b0});
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1011, 1'b0});
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1011, 1'b0});
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b1011, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b1111, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0});

        // Reset state
        ticks(2);
        rst = 1'b0;
        check("rst_armed", armed, 1'b0);
        check("rst_winner", {winner_valid, winner}, '0);
        check("rst_lockout", lockout, '0);
        check("rst_pulses", {timeout, round_done}, '0);
        check("rst_scores", scores, '0);

        // Directed vector table: latency, priority, wrong-answer lockouts
        foreach (tbl[k]) begin
            start_round     = tbl[k].st;
            buzzer          = tbl[k].bz;
            verdict_valid   = tbl[k].vv;
            verdict_correct = tbl[k].vc;
            tick();
            check($sformatf("vec%0d", k), {armed, winner, lockout, round_done},
                  {tbl[k].e_armed, tbl[k].e_win, tbl[k].e_lock, tbl[k].e_done});
        end
        start_round = 1'b0;
        verdict_valid = 1'b0;
        check("vec_score2", scores[2*SW +: SW], 8'd1);
        check("vec_score1", scores[1*SW +: SW], 8'd1);

        // Timeout with no verdict
        start_round = 1'b1;
        tick();
        start_round = 1'b0;
        check("tmo_lock_clear", lockout, 4'b0000);
        buzzer = 4'b1000;
        ticks(3);
        check("tmo_win", winner, 4'b1000);
        buzzer = 4'b0000;
        for (int i = 1; i < AC; i++) begin
            tick();
            check($sformatf("tmo_quiet%0d", i), timeout, 1'b0);
        end
        tick();
        check("tmo_pulse", {timeout, armed, winner, lockout}, {1'b1, 1'b1, 4'b0000, 4'b1000});
        tick();
        check("tmo_pulse_end", timeout, 1'b0);

        // Verdict on the expiry cycle suppresses timeout
        buzzer = 4'b0001;
        ticks(3);
        check("exp_win", winner, 4'b0001);
        buzzer = 4'b0000;
        ticks(AC - 1);
        verdict_valid = 1'b1;
        verdict_correct = 1'b0;
        tick();
        verdict_valid = 1'b0;
        check("exp_no_tmo", {timeout, armed, lockout}, {1'b0, 1'b1, 4'b1001});

        // Asynchronous reset during the answer window
        buzzer = 4'b0010;
        ticks(3);
        check("ar_win", winner, 4'b0010);
        buzzer = 4'b0000;
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("ar_async", {armed, winner_valid, timeout, round_done, winner, lockout, scores}, '0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("ar_idle%0d", i), armed, 1'b0);
        end

        // False start in idle, and held buttons never re-trigger
        buzzer = 4'b0010;
        ticks(4);
        start_round = 1'b1;
        tick();
        start_round = 1'b0;
        check("fs_lock", {armed, lockout}, {1'b1, 4'b0010});
        buzzer = 4'b0000;
        tick();
        buzzer = 4'b0010;
        ticks(3);
        check("fs_nowin", {armed, winner}, {1'b1, 4'b0000});
        buzzer = 4'b0110;
        ticks(3);
        check("fs_other_win", winner, 4'b0100);
        verdict_valid = 1'b1;
        verdict_correct = 1'b1;
        tick();
        verdict_valid = 1'b0;
        ticks(2);
        start_round = 1'b1;
        tick();
        start_round = 1'b0;
        ticks(4);
        check("held_no_retrig", {armed, winner, lockout}, {1'b1, 4'b0000, 4'b0000});
        buzzer = 4'b0000;
        tick();
        buzzer = 4'b1000;
        ticks(3);
        check("held_new_win", winner, 4'b1000);
        buzzer = 4'b0000;
        verdict_valid = 1'b1;
        tick();
        verdict_valid = 1'b0;
        ticks(2);

        // Score saturation for user 0
        for (int r = 0; r < SMAX; r++) round_user0();
        check("sat_max", scores[0 +: SW], 8'd255);
        round_user0();
        check("sat_hold", scores[0 +: SW], 8'd255);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] flip;
            flip = '0;
            for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 5) == 0);
            buzzer          = buzzer ^ flip;
            start_round     = ($urandom_range(0, 7) == 0);
            verdict_valid   = ($urandom_range(0, 4) == 0);
            verdict_correct = 1'($urandom_range(0, 1));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/quiz_round_controller.md
# quiz_round_controller

Round sequencer and arbiter for the fastest-finger-first quiz system. It owns one question round at a time. It arms the buzzers and resolves which of N contestants buzzed first. It locks out false starters and contestants who answered wrong, runs a bounded answer window for the winner, and keeps a per-contestant score. The host console drives it through start and verdict strobes. Outputs feed winner lamps and score displays.

## Interface
Parameters:
- N_USERS, default 4: number of contestants (2..8).
- ANSWER_CYCLES, default 1000: answer-window length in clk cycles (≥2).
- SCORE_W, default 8: width of each score counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_round  in  1  host strobe; opens a new round.
- buzzer  in  N_USERS  raw contestant buttons, asynchronous, active-high.
- verdict_valid  in  1  host strobe; a verdict is present.
- verdict_correct  in  1  qualifies verdict_valid: 1 = correct, 0 = wrong.
- armed  out  1  high while buzzers are accepted.
- winner  out  N_USERS  one-hot; the current answering contestant, zero otherwise.
- winner_valid  out  1  high while winner is non-zero.
- lockout  out  N_USERS  contestants barred for the rest of the round.
- timeout  out  1  one-cycle pulse when the answer window expires.
- round_done  out  1  one-cycle pulse when the round closes.
- scores  out  N_USERS*SCORE_W  packed scores; user i sits at [i*SCORE_W +: SCORE_W].

## Operation
- Input conditioning: each buzzer bit passes through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~sync2_d). Only edges count; a held button never re-triggers.
- States:
  - IDLE: armed=0. start_round moves to ARMED and clears lockout.
  - ARMED: armed=1. Among the edges from non-locked users, the lowest index wins. On a win, winner is loaded, the answer counter is loaded with ANSWER_CYCLES-1, and the state moves to ANSWER.
  - ANSWER: armed=0. The counter decrements each cycle. verdict_valid with verdict_correct=1 adds 1 to the winner's score, then goes to CLOSE. verdict_valid with verdict_correct=0 sets the winner's lockout bit. An expired counter (value 0 with no verdict that cycle) pulses timeout and is treated as wrong. After a wrong or timeout:
    - if every user is locked, go to CLOSE;
    - otherwise clear winner and return to ARMED.
  - CLOSE: pulse round_done for 1 cycle, clear winner, go to IDLE.
- False start: a detected edge while in IDLE sets that user's lockout bit for the next round. start_round does not clear false-start bits set in the same IDLE period; it clears all other lockout bits.
- Edges that arrive during ANSWER or CLOSE are discarded. They are not queued.
- Verdicts outside ANSWER are ignored. start_round outside IDLE is ignored.
- Scores saturate at 2^SCORE_W-1. Scores are cleared only by rst.
- Verdict on the expiry cycle: the verdict takes priority and timeout does not pulse.

## Timing
- Reset values: state IDLE; armed=0, winner=0, winner_valid=0, lockout=0, timeout=0, round_done=0, scores=0; synchronizers 0.
- Buzzer to winner latency: buzzer high before edge k, with state ARMED at k+2, gives winner and winner_valid high after edge k+2. That is 3 edges.
- start_round sampled at edge k: armed=1 after edge k.
- Answer window: winner set at edge w. With no verdict, timeout pulses after edge w+ANSWER_CYCLES. A verdict sampled at any edge w+1..w+ANSWER_CYCLES is honoured.
- Correct verdict at edge v: the score updates after v, round_done pulses after v+1, and the state is IDLE after v+1.
- Wrong verdict at edge v: lockout updates and the state returns to ARMED after v (armed=1), with winner=0. A new buzzer edge can win from that cycle onward.
- Simultaneous edges in the same cycle: the lowest index wins. The losers are not locked and may buzz again if re-armed.
- rst asserted mid-round returns all outputs to reset values immediately, without waiting for clk.

## Test plan
Bench settings: N_USERS=4, ANSWER_CYCLES=8, SCORE_W=8.
- Reset then start_round, buzzer[2] rises -> winner=4'b0100 exactly 3 edges later, armed drops; correct verdict -> scores[2]=1, single round_done pulse.
- Arm, then buzzer[1] and buzzer[3] rise in the same cycle -> winner=4'b0010, lockout=0.
- Winner user 0, wrong verdict -> lockout=4'b0001, armed=1; buzzer[0] press ignored; buzzer[3] -> winner=4'b1000; repeat wrong for the rest -> round_done after lockout=4'b1111.
- Winner set and no verdict -> timeout pulse 8 cycles later, winner's lockout bit set, back to ARMED; a verdict on the expiry cycle instead -> no timeout pulse.
- buzzer[1] pressed in IDLE then start_round -> lockout=4'b0010, user 1 cannot win; held buttons never re-trigger; 255 correct answers for user 0 then one more -> scores[0] stays 255.
- rst pulsed during ANSWER -> all outputs 0 asynchronously; after release, the block stays in IDLE until start_round.
